// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Consumes a byte stream (2-byte big-endian word count, then big-endian words),
// writes each assembled word into instruction memory at consecutive word
// addresses, and holds the CPU in reset until the final write has landed.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_HDR_HI = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_LAST   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Number of words the instruction memory can hold; wider than the word
  // counter so the comparison stays exact for any ADDR_W up to 32.
  localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

  logic [2:0]  state_q,    state_d;
  logic [15:0] n_q,        n_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [23:0] shift_q,    shift_d;
  logic        we_q,       we_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic        err_q,      err_d;

  logic        stream_state;
  logic        xfer;
  logic        overflow;
  logic        last_word;
  logic [31:0] full_word;

  // Only the header and data states take bytes; reset forces ready low at once.
  assign stream_state = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA);
  assign in_ready     = stream_state & ~rst;
  assign xfer         = in_valid & in_ready;

  // A word whose index falls outside the memory is still consumed but not written.
  assign overflow  = ({17'd0, word_cnt_q} >= DEPTH);
  assign last_word = (word_cnt_q == (n_q - 16'd1));
  assign full_word = {shift_q, in_data};

  // Next-state, header latch, byte assembly and write-strobe generation.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;

    case (state_q)
      S_HDR_HI: begin
        if (xfer) begin
          n_d[15:8] = in_data;
          state_d   = S_HDR_LO;
        end
      end

      S_HDR_LO: begin
        if (xfer) begin
          n_d[7:0]   = in_data;
          byte_cnt_d = 2'd0;
          word_cnt_d = 16'd0;
          // An empty image releases the CPU straight away.
          if ({n_q[15:8], in_data} == 16'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          if (byte_cnt_q == 2'd3) begin
            if (overflow) begin
              err_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              addr_d  = {14'd0, word_cnt_q, 2'b00};
              wdata_d = full_word;
            end
            byte_cnt_d = 2'd0;
            word_cnt_d = word_cnt_q + 16'd1;
            if (last_word) begin
              state_d = S_LAST;
            end
          end else begin
            // First byte of a word lands in the most significant position.
            shift_d    = {shift_q[15:0], in_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      // The final strobe is on the bus this cycle; memory takes it on the next edge.
      S_LAST: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_HDR_HI;
      end
    endcase
  end

  // State and output registers; reset takes effect immediately.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q    <= S_HDR_HI;
      n_q        <= 16'd0;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 16'd0;
      shift_q    <= 24'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign done      = (state_q == S_DONE);
  assign cpu_rst   = ~done;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table-driven cycle vectors for the
// continuous two-word and empty images, plus hand-written sequences for
// valid gaps, memory overflow and reset in the middle of a load.
module tb_imem_loader;

  logic        CLK;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready, mem_we, cpu_rst, done, err;
  logic [31:0] mem_addr, mem_wdata;

  logic        o_ready, o_we, o_cpu_rst, o_done, o_err;
  logic [31:0] o_addr, o_wdata;

  imem_loader dut (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  // Small-memory instance (4 words) for the overflow case; shares the stream.
  imem_loader #(.ADDR_W(2)) dut_ovf (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(o_ready), .mem_we(o_we), .mem_addr(o_addr),
    .mem_wdata(o_wdata), .cpu_rst(o_cpu_rst), .done(o_done), .err(o_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dn;
    logic        crst;
    logic        e;
  } vec_t;

  vec_t tbl [0:15];
  int   n_cmp;
  int   n_fail;

  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [31:0] ow_addr [$];
  logic [31:0] ow_data [$];
  int          stretch;
  logic        prev_we, prev_owe;

  // Write monitors: record every strobe and flag any strobe longer than one cycle.
  always @(negedge CLK) begin
    if (rst) begin
      prev_we  = 1'b0;
      prev_owe = 1'b0;
    end else begin
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
        $display("write   addr=%h data=%h", mem_addr, mem_wdata);
        if (prev_we) stretch++;
      end
      if (o_we) begin
        ow_addr.push_back(o_addr);
        ow_data.push_back(o_wdata);
        $display("write4w addr=%h data=%h", o_addr, o_wdata);
        if (prev_owe) stretch++;
      end
      prev_we  = mem_we;
      prev_owe = o_we;
    end
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic put(input int i, input logic v, input logic [7:0] d, input logic rdy,
                     input logic we, input logic [31:0] a, input logic [31:0] w,
                     input logic dn, input logic crst, input logic e);
    tbl[i] = '{v, d, rdy, we, a, w, dn, crst, e};
  endtask

  // Expected cycle-by-cycle view of the two-word image 00 02 20080005 8C090004.
  task automatic load_two();
    put(0,  1, 8'h00, 1, 0, 32'h0, 32'h0,        0, 1, 0);
    put(1,  1, 8'h02, 1, 0, 32'h0, 32'h0,        0, 1, 0);
    put(2,  1, 8'h20, 1, 0, 32'h0, 32'h0,        0, 1, 0);
    put(3,  1, 8'h08, 1, 0, 32'h0, 32'h0,        0, 1, 0);
    put(4,  1, 8'h00, 1, 0, 32'h0, 32'h0,        0, 1, 0);
    put(5,  1, 8'h05, 1, 0, 32'h0, 32'h0,        0, 1, 0);
    put(6,  1, 8'h8C, 1, 1, 32'h0, 32'h20080005, 0, 1, 0);
    put(7,  1, 8'h09, 1, 0, 32'h0, 32'h20080005, 0, 1, 0);
    put(8,  1, 8'h00, 1, 0, 32'h0, 32'h20080005, 0, 1, 0);
    put(9,  1, 8'h04, 1, 0, 32'h0, 32'h20080005, 0, 1, 0);
    put(10, 0, 8'h00, 0, 1, 32'h4, 32'h8C090004, 0, 1, 0);
    put(11, 0, 8'h00, 0, 0, 32'h4, 32'h8C090004, 1, 0, 0);
    put(12, 1, 8'hFF, 0, 0, 32'h4, 32'h8C090004, 1, 0, 0);
    put(13, 0, 8'h00, 0, 0, 32'h4, 32'h8C090004, 1, 0, 0);
  endtask

  // Empty image: done right after the second header byte, later bytes ignored.
  task automatic load_zero();
    put(0, 1, 8'h00, 1, 0, 32'h0, 32'h0, 0, 1, 0);
    put(1, 1, 8'h00, 1, 0, 32'h0, 32'h0, 0, 1, 0);
    put(2, 1, 8'hAB, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    put(3, 1, 8'hCD, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    put(4, 0, 8'h00, 0, 0, 32'h0, 32'h0, 1, 0, 0);
  endtask

  task automatic apply_table(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      #1;
      chk("in_ready",  i, {31'd0, in_ready},  {31'd0, tbl[i].rdy});
      chk("mem_we",    i, {31'd0, mem_we},    {31'd0, tbl[i].we});
      chk("mem_addr",  i, mem_addr,           tbl[i].addr);
      chk("mem_wdata", i, mem_wdata,          tbl[i].wdata);
      chk("done",      i, {31'd0, done},      {31'd0, tbl[i].dn});
      chk("cpu_rst",   i, {31'd0, cpu_rst},   {31'd0, tbl[i].crst});
      chk("err",       i, {31'd0, err},       {31'd0, tbl[i].e});
    end
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    @(negedge CLK);
    #2 rst = 1'b0;
    wr_addr.delete(); wr_data.delete();
    ow_addr.delete(); ow_data.delete();
  endtask

  // Present one byte after `gap` idle cycles; the transfer happens on the next rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      @(negedge CLK);
      in_valid = 1'b0;
    end
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CLK);
      in_valid = 1'b1;
      in_data  = b;
      #1;
      ok = in_ready;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %h", b);
    end
  endtask

  logic [7:0]  img [0:9];
  logic [31:0] ovf_exp [0:3];

  initial begin
    n_cmp = 0; n_fail = 0; stretch = 0;
    prev_we = 1'b0; prev_owe = 1'b0;
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    ovf_exp = '{32'h01020304, 32'h11121314, 32'h21222324, 32'h31323334};

    // Reset pulse at 10 ns: outputs at reset values while asserted.
    #10 rst = 1'b1;
    #2;
    chk("rst_in_ready",  0, {31'd0, in_ready}, 32'd0);
    chk("rst_mem_we",    0, {31'd0, mem_we},   32'd0);
    chk("rst_mem_addr",  0, mem_addr,          32'd0);
    chk("rst_mem_wdata", 0, mem_wdata,         32'd0);
    chk("rst_cpu_rst",   0, {31'd0, cpu_rst},  32'd1);
    chk("rst_done",      0, {31'd0, done},     32'd0);
    chk("rst_err",       0, {31'd0, err},      32'd0);
    #8 rst = 1'b0;
    #1;
    chk("rel_in_ready", 0, {31'd0, in_ready}, 32'd1);
    chk("rel_cpu_rst",  0, {31'd0, cpu_rst},  32'd1);
    wr_addr.delete(); wr_data.delete();
    ow_addr.delete(); ow_data.delete();

    // Two-word image, continuous valid.
    load_two();
    apply_table(14);
    chk("two_nwrites", 0, wr_addr.size(), 32'd2);

    // Same image with random valid gaps.
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(img[i], int'($urandom_range(0, 3)));
    @(negedge CLK);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !done; k++) @(negedge CLK);
    #1;
    chk("gap_done",    0, {31'd0, done},    32'd1);
    chk("gap_cpu_rst", 0, {31'd0, cpu_rst}, 32'd0);
    chk("gap_nwrites", 0, wr_addr.size(),   32'd2);
    if (wr_addr.size() == 2) begin
      chk("gap_addr",  0, wr_addr[0], 32'h0);
      chk("gap_data",  0, wr_data[0], 32'h20080005);
      chk("gap_addr",  1, wr_addr[1], 32'h4);
      chk("gap_data",  1, wr_data[1], 32'h8C090004);
    end

    // Empty image.
    do_reset();
    load_zero();
    apply_table(5);
    chk("zero_nwrites", 0, wr_addr.size(), 32'd0);

    // Overflow: five words into a four-word memory.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (w == 4 && b == 3) begin
          chk("ovf_err_before", 0, {31'd0, o_err}, 32'd0);
        end
        send_byte({w[3:0], 4'(b + 1)}, 0);
      end
    end
    @(negedge CLK);
    in_valid = 1'b0;
    #1;
    chk("ovf_err",       0, {31'd0, o_err},     32'd1);
    chk("ovf_we_supp",   0, {31'd0, o_we},      32'd0);
    chk("ovf_ready",     0, {31'd0, o_ready},   32'd0);
    chk("ovf_done_last", 0, {31'd0, o_done},    32'd0);
    chk("big_err",       0, {31'd0, err},       32'd0);
    @(negedge CLK);
    #1;
    chk("ovf_done",    0, {31'd0, o_done},    32'd1);
    chk("ovf_cpu_rst", 0, {31'd0, o_cpu_rst}, 32'd0);
    chk("ovf_nwrites", 0, ow_addr.size(),     32'd4);
    if (ow_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("ovf_addr", i, ow_addr[i], 32'(i * 4));
        chk("ovf_data", i, ow_data[i], ovf_exp[i]);
      end
    end
    chk("big_nwrites", 0, wr_addr.size(), 32'd5);

    // Reset after six data bytes, then a full reload.
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(img[i], 0);
    @(negedge CLK);
    in_valid = 1'b0;
    #1;
    chk("mid_wdata_pre", 0, mem_wdata, 32'h20080005);
    #1 rst = 1'b1;
    #1;
    chk("mid_in_ready", 0, {31'd0, in_ready}, 32'd0);
    chk("mid_mem_we",   0, {31'd0, mem_we},   32'd0);
    chk("mid_mem_addr", 0, mem_addr,          32'd0);
    chk("mid_mem_wdata",0, mem_wdata,         32'd0);
    chk("mid_cpu_rst",  0, {31'd0, cpu_rst},  32'd1);
    chk("mid_done",     0, {31'd0, done},     32'd0);
    @(negedge CLK);
    #2 rst = 1'b0;
    #1;
    chk("mid_rel_ready", 0, {31'd0, in_ready}, 32'd1);
    wr_addr.delete(); wr_data.delete();
    ow_addr.delete(); ow_data.delete();
    load_two();
    apply_table(14);
    chk("reload_nwrites", 0, wr_addr.size(), 32'd2);

    chk("we_stretch", 0, stretch, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
